// File: rtl/dom_pkg.sv
// Shared GF(2^2) definitions for the masked multiplier and its reference models.
package dom_pkg;

  localparam int GF4_W = 2;

  typedef logic [GF4_W-1:0] gf4_t;

  // Polynomial-basis product modulo w^2+w+1.
  function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
    gf4_t c;
    c[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    c[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return c;
  endfunction

endpackage

// File: rtl/dom_dep_gf4_multiplier_gf4_mul.sv
// Purely combinational GF(2^2) multiplier, polynomial basis, modulus w^2+w+1.
module gf4_mul
  import dom_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] c
);

  gf4_t prod;

  // Product bits written out explicitly so each instance is a small AND/XOR cone.
  always_comb begin
    prod    = '0;
    prod[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    prod[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
  end

  assign c = prod;

endmodule

// File: rtl/dom_dep_gf4_multiplier.sv
// First-order DOM-dep multiplier over GF(2^2). Y is blinded by Z, the blinded
// value is unmasked, and X*Z is computed with an inner DOM-indep resharing so
// that the domain-A/domain-B shares of the output XOR to X*Y one cycle later.
module dom_dep_gf4_multiplier
  import dom_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Ax,
  input  logic [1:0] Ay,
  input  logic [1:0] Az,
  input  logic [1:0] Bx,
  input  logic [1:0] By,
  input  logic [1:0] Bz,
  input  logic [1:0] Z,
  output logic [1:0] Aq,
  output logic [1:0] Bq
);

  // Stage 0: combinational terms formed from the input shares.
  gf4_t in_a_p0, in_b_p0;
  gf4_t xz_ab_p0, xz_ba_p0;
  gf4_t cr_a_p0, cr_b_p0;
  gf4_t yz_a_p0, yz_b_p0;

  gf4_mul u_in_a  (.a(Ax), .b(Az), .c(in_a_p0));
  gf4_mul u_in_b  (.a(Bx), .b(Bz), .c(in_b_p0));
  gf4_mul u_cr_a  (.a(Ax), .b(Bz), .c(xz_ab_p0));
  gf4_mul u_cr_b  (.a(Bx), .b(Az), .c(xz_ba_p0));

  assign cr_a_p0 = xz_ab_p0 ^ Z;
  assign cr_b_p0 = xz_ba_p0 ^ Z;
  assign yz_a_p0 = Ay ^ Az;
  assign yz_b_p0 = By ^ Bz;

  // Stage 1: register every term; the cross-domain products must settle here
  // before they meet any same-domain term, so this stage is the glitch barrier.
  gf4_t yz_a_p1, yz_b_p1;
  gf4_t x_a_p1, x_b_p1;
  gf4_t in_a_p1, in_b_p1;
  gf4_t cr_a_p1, cr_b_p1;

  // Capture all stage-1 terms; reset discards any in-flight product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yz_a_p1 <= '0;
      yz_b_p1 <= '0;
      x_a_p1  <= '0;
      x_b_p1  <= '0;
      in_a_p1 <= '0;
      in_b_p1 <= '0;
      cr_a_p1 <= '0;
      cr_b_p1 <= '0;
    end else begin
      yz_a_p1 <= yz_a_p0;
      yz_b_p1 <= yz_b_p0;
      x_a_p1  <= Ax;
      x_b_p1  <= Bx;
      in_a_p1 <= in_a_p0;
      in_b_p1 <= in_b_p0;
      cr_a_p1 <= cr_a_p0;
      cr_b_p1 <= cr_b_p0;
    end
  end

  // Output: combine registered terms only. Y^Z is safe to unmask since Z is
  // uniformly random and independent of Y.
  gf4_t b_p1;
  gf4_t xb_a_p1, xb_b_p1;

  assign b_p1 = yz_a_p1 ^ yz_b_p1;

  gf4_mul u_xb_a (.a(x_a_p1), .b(b_p1), .c(xb_a_p1));
  gf4_mul u_xb_b (.a(x_b_p1), .b(b_p1), .c(xb_b_p1));

  assign Aq = xb_a_p1 ^ in_a_p1 ^ cr_a_p1;
  assign Bq = xb_b_p1 ^ in_b_p1 ^ cr_b_p1;

endmodule

// File: tb/tb_dom_dep_gf4_multiplier.sv
// Bench for dom_dep_gf4_multiplier: randomized share splits and blinding,
// outputs recombined and compared with a carry-less-multiply-and-reduce model.
module tb_dom_dep_gf4_multiplier;

  logic       clk;
  logic       rst_n;
  logic [1:0] ax, ay, az, bx, by, bz, zr;
  logic [1:0] aq, bq;

  int checks = 0;
  int errors = 0;

  dom_dep_gf4_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Ax    (ax),
    .Ay    (ay),
    .Az    (az),
    .Bx    (bx),
    .By    (by),
    .Bz    (bz),
    .Z     (zr),
    .Aq    (aq),
    .Bq    (bq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook carry-less product, then reduce w^2 -> w+1.
  function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] p;
    p = 3'b000;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (a[i] && b[j]) p[i+j] = ~p[i+j];
    if (p[2]) p = p ^ 3'b111;
    return p[1:0];
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_rand(input logic [1:0] x, input logic [1:0] y);
    ax = 2'($urandom());
    ay = 2'($urandom());
    az = 2'($urandom());
    bz = 2'($urandom());
    zr = 2'($urandom());
    bx = x ^ ax;
    by = y ^ ay;
  endtask

  // Drive one product, let the next edge capture it, then check the recombined output.
  task automatic step(input logic [1:0] x, input logic [1:0] y, input string tag);
    drive_rand(x, y);
    @(posedge clk);
    #1;
    chk(tag, aq ^ bq, ref_mul(x, y));
  endtask

  logic [3:0] aq_seen;
  logic [1:0] xr, yr;

  initial begin
    rst_n = 1'b0;
    drive_rand(2'($urandom()), 2'($urandom()));

    // Reset holds outputs at zero regardless of inputs and clock edges.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_aq", aq, 2'd0);
    chk("reset_bq", bq, 2'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Directed example from the worked case.
    ax = 2'd0; ay = 2'd2; az = 2'd1;
    bx = 2'd1; by = 2'd1; bz = 2'd1;
    zr = 2'd2;
    @(posedge clk);
    #1;
    chk("directed_aq", aq, 2'd2);
    chk("directed_bq", bq, 2'd1);
    chk("directed_q", aq ^ bq, 2'd3);

    // Exhaustive over X,Y, back-to-back, twice with fresh randomness.
    for (int r = 0; r < 2; r++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          step(2'(x), 2'(y), $sformatf("exh_x%0d_y%0d", x, y));

    // Field identities.
    step(2'd2, 2'd2, "field_2x2");
    step(2'd3, 2'd3, "field_3x3");
    step(2'd2, 2'd3, "field_2x3");
    step(2'd0, 2'($urandom()), "field_x0");
    step(2'($urandom()), 2'd0, "field_y0");

    // Randomness independence: fixed X=3,Y=2 while Z and Az sweep.
    aq_seen = 4'b0000;
    for (int zi = 0; zi < 4; zi++)
      for (int ai = 0; ai < 4; ai++) begin
        drive_rand(2'd3, 2'd2);
        zr = 2'(zi);
        az = 2'(ai);
        @(posedge clk);
        #1;
        chk($sformatf("indep_z%0d_az%0d", zi, ai), aq ^ bq, 2'd1);
        aq_seen[aq] = 1'b1;
      end
    chk("indep_aq_varies", ($countones(aq_seen) > 1) ? 2'd1 : 2'd0, 2'd1);

    // Random streaming.
    for (int k = 0; k < 40; k++) begin
      xr = 2'($urandom());
      yr = 2'($urandom());
      step(xr, yr, $sformatf("rand_%0d", k));
    end

    // Asynchronous reset between edges during streaming.
    step(2'd3, 2'd3, "pre_reset");
    drive_rand(2'd2, 2'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_aq", aq, 2'd0);
    chk("midrst_bq", bq, 2'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_aq", aq, 2'd0);
    chk("midrst_hold_bq", bq, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(2'd2, 2'd2, "post_reset_first");
    step(2'd3, 2'd1, "post_reset_second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
